// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that drives the 32-bit ALU for every add and shift.
// It holds M, Q and the partial product P, and reports the result over a Start/Done handshake.
module alu_mul_sequencer #(
  parameter int unsigned MUL_W   = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      Multiplicand,
  input  logic [MUL_W-1:0] Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      Product,
  output logic             Overflow,
  output logic [31:0]      AluA,
  output logic [31:0]      AluB,
  output logic [4:0]       AluFunSel,
  output logic             AluWF,
  input  logic [31:0]      AluOut,
  input  logic [3:0]       AluFlags
);

  localparam logic [4:0] FunNop = 5'b10000;
  localparam logic [4:0] FunAdd = 5'b10100;
  localparam logic [4:0] FunLsl = 5'b11011;
  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StTest, StAddI, StAddW, StShlI, StShlW, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      m_q, m_d, p_q, p_d, product_q, product_d;
  logic [MUL_W-1:0] q_q, q_d;
  logic             ovf_q, ovf_d, overflow_q, overflow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_wait, carry, q_left;

  // Only the carry flag matters; Z/N/O are deliberately ignored.
  logic unused_flags;
  assign unused_flags = ^{AluFlags[3], AluFlags[1:0]};

  assign last_wait = (cnt_q == CntW'(ALU_LAT - 1));
  assign carry     = AluFlags[2];
  assign q_left    = ((q_q >> 1) != '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      m_q        <= '0;
      q_q        <= '0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      p_q        <= p_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    p_d        = p_q;
    ovf_d      = ovf_q;
    cnt_d      = '0;
    product_d  = product_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          m_d     = Multiplicand;
          q_d     = Multiplier;
          p_d     = '0;
          ovf_d   = 1'b0;
          state_d = StTest;
        end
      end
      StTest: begin
        if (q_q == '0) begin
          // Result registers load here so they are already valid during the Done cycle.
          product_d  = p_q;
          overflow_d = ovf_q;
          state_d    = StDone;
        end else if (q_q[0]) begin
          state_d = StAddI;
        end else begin
          state_d = StShlI;
        end
      end
      StAddI: state_d = StAddW;
      StAddW: begin
        cnt_d = cnt_q + 1'b1;
        if (last_wait) begin
          cnt_d   = '0;
          p_d     = AluOut;
          ovf_d   = ovf_q | carry;
          state_d = StShlI;
        end
      end
      StShlI: state_d = StShlW;
      StShlW: begin
        cnt_d = cnt_q + 1'b1;
        if (last_wait) begin
          cnt_d   = '0;
          m_d     = AluOut;
          q_d     = q_q >> 1;
          // Bits shifted out of M only matter if a later multiplier bit will add them in.
          ovf_d   = ovf_q | (carry & q_left);
          state_d = StTest;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluFunSel = FunNop;
    AluWF     = 1'b0;
    case (state_q)
      StAddI, StAddW: begin
        AluA      = p_q;
        AluB      = m_q;
        AluFunSel = FunAdd;
        AluWF     = (state_q == StAddI);
      end
      StShlI, StShlW: begin
        AluA      = m_q;
        AluFunSel = FunLsl;
        AluWF     = (state_q == StShlI);
      end
      default: ;
    endcase
    Busy     = (state_q != StIdle);
    Done     = (state_q == StDone);
    Product  = product_q;
    Overflow = overflow_q;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural 32-bit ALU responder.
// Expected products, overflow, latency and ALU issue counts come from plain arithmetic.
module tb_alu_mul_sequencer;

  localparam int unsigned MUL_W   = 16;
  localparam int unsigned ALU_LAT = 1;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [31:0]      Multiplicand = '0;
  logic [MUL_W-1:0] Multiplier = '0;
  logic             Busy, Done, Overflow, AluWF;
  logic [31:0]      Product, AluA, AluB, AluOut;
  logic [4:0]       AluFunSel;
  logic [3:0]       AluFlags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_sequencer #(.MUL_W(MUL_W), .ALU_LAT(ALU_LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Multiplicand(Multiplicand),
    .Multiplier(Multiplier), .Busy(Busy), .Done(Done), .Product(Product),
    .Overflow(Overflow), .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags)
  );

  always #5 Clock = ~Clock;

  // ALU model: result appears ALU_LAT edges after FunSel is sampled; carry written only on WF.
  logic [32:0] alu_r;
  logic [32:0] pipe [ALU_LAT];
  logic        flag_c = 1'b0;

  always_comb begin
    case (AluFunSel)
      5'b10100: alu_r = {1'b0, AluA} + {1'b0, AluB};
      5'b11011: alu_r = {AluA, 1'b0};
      default:  alu_r = {1'b0, AluA};
    endcase
  end

  always @(posedge Clock) begin
    if (AluWF) flag_c <= alu_r[32];
    pipe[0] <= {AluWF ? alu_r[32] : flag_c, alu_r[31:0]};
    for (int i = 1; i < int'(ALU_LAT); i++) pipe[i] <= pipe[i-1];
  end

  assign AluOut   = pipe[ALU_LAT-1][31:0];
  assign AluFlags = {1'b0, pipe[ALU_LAT-1][32], 2'b00};

  // Write-enable scoreboard: every WF pulse must be a lone add/shift issue.
  int   wf_count = 0;
  int   wf_bad   = 0;
  logic wf_prev  = 1'b0;
  always @(posedge Clock) begin
    wf_prev <= AluWF;
    if (AluWF) begin
      wf_count <= wf_count + 1;
      if (wf_prev || !(AluFunSel == 5'b10100 || AluFunSel == 5'b11011)) wf_bad <= wf_bad + 1;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({Busy, Done, Product, Overflow, AluA, AluB, AluFunSel, AluWF} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 5'b10000, 1'b0}) begin
      n_fail++;
      $display("FAIL %s outputs: got busy=%b done=%b prod=%h ovf=%b a=%h b=%h fs=%b wf=%b, want reset values",
               tag, Busy, Done, Product, Overflow, AluA, AluB, AluFunSel, AluWF);
    end
  endtask

  // Starts an op in the current cycle, returns in the cycle after Done.
  task automatic run_op(input logic [31:0] m, input logic [15:0] q, input bit poke_busy,
                        input string tag);
    logic [63:0] full;
    int n1, n0, h, exp_lat, cyc, busy_err, wf0, bad0;
    bit got;
    full = 64'(m) * 64'(q);
    n1 = 0; n0 = 0; h = -1;
    for (int i = 0; i < int'(MUL_W); i++) if (q[i]) h = i;
    for (int i = 0; i <= h; i++) if (q[i]) n1++; else n0++;
    exp_lat = 2 + n1 * (3 + 2 * int'(ALU_LAT)) + n0 * (2 + int'(ALU_LAT));
    wf0 = wf_count; bad0 = wf_bad;
    Multiplicand = m; Multiplier = q; Start = 1'b1;
    cyc = 0; busy_err = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      Start = 1'b0;
      if (poke_busy && cyc == 2) begin
        Start = 1'b1; Multiplicand = ~m; Multiplier = 16'h00FF;
      end
      if (!Busy) busy_err++;
      if (Done) got = 1'b1;
    end
    Start = 1'b0;
    n_checks++;
    if (!got || cyc !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (done seen=%0d) want %0d", tag, cyc, got, exp_lat);
    end
    n_checks++;
    if (Product !== full[31:0]) begin
      n_fail++;
      $display("FAIL %s product: got %h want %h", tag, Product, full[31:0]);
    end
    n_checks++;
    if (Overflow !== (full[63:32] != 0)) begin
      n_fail++;
      $display("FAIL %s overflow: got %b want %b", tag, Overflow, full[63:32] != 0);
    end
    n_checks++;
    if (busy_err !== 0) begin
      n_fail++;
      $display("FAIL %s busy: got %0d low cycles want 0", tag, busy_err);
    end
    n_checks++;
    if ((wf_count - wf0) !== 2 * n1 + n0 || (wf_bad - bad0) !== 0) begin
      n_fail++;
      $display("FAIL %s alu_wf: got %0d issues (%0d bad) want %0d (0 bad)", tag,
               wf_count - wf0, wf_bad - bad0, 2 * n1 + n0);
    end
    tick();
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Product !== full[31:0]) begin
      n_fail++;
      $display("FAIL %s post_done: got done=%b busy=%b prod=%h want 0 0 %h", tag, Done, Busy,
               Product, full[31:0]);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Multiplicand = 32'd9; Multiplier = 16'd9;
    repeat (3) tick();
    check_reset_outputs("reset");
    Reset = 1'b0; Start = 1'b0;
    tick();
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_basic();
    run_op(32'd3, 16'd5, 1'b0, "basic_3x5");
    tick();
    run_op(32'h1234, 16'd0, 1'b0, "zero_q");
    tick();
    run_op(32'h0000FFFF, 16'hFFFF, 1'b0, "max_q");
  endtask

  task automatic test_overflow();
    tick();
    run_op(32'h80000000, 16'd3, 1'b0, "ovf_set");
    tick();
    run_op(32'd2, 16'd2, 1'b0, "ovf_clear");
  endtask

  task automatic test_start_while_busy();
    tick();
    run_op(32'd1000, 16'h0A5A, 1'b1, "busy_start");
  endtask

  task automatic test_back_to_back();
    tick();
    run_op(32'd5, 16'd9, 1'b0, "b2b_first");
    run_op(32'd7, 16'd6, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] m;
    logic [15:0] q;
    for (int i = 0; i < 20; i++) begin
      m = $urandom;
      q = 16'($urandom);
      if (i % 4 == 0) q = 16'($urandom_range(0, 15));
      if (i % 5 == 1) m = $urandom_range(0, 1000);
      run_op(m, q, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    tick();
    Multiplicand = 32'h0000FFFF; Multiplier = 16'hFFFF; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    check_reset_outputs("reset_mid_op");
    Reset = 1'b0;
    dones = 0;
    repeat (100) begin
      tick();
      if (Done || Busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d done/busy cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
